// File: rtl/uart_rx_if.sv
// uart_rx_if: byte stream and error status between the UART receiver and its consumer.
`default_nettype none

interface uart_rx_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       frame_err;
   logic       overrun;
   logic       err_clear;

   modport master (
      output rx_data, rx_valid, frame_err, overrun,
      input  rx_ready, err_clear
   );

   modport slave (
      input  rx_data, rx_valid, frame_err, overrun,
      output rx_ready, err_clear
   );
endinterface

`default_nettype wire

// File: rtl/uart_rx.sv
// uart_rx: 8N1 oversampling UART receiver feeding a show-ahead FIFO (rev 1.0).
`default_nettype none

module uart_rx #(
   parameter int CLKS_PER_BIT = 217,
   parameter int DEPTH        = 4
) (
   input  wire logic     CLK,
   input  wire logic     RST_N,
   input  wire logic     uart_line_in,
   uart_rx_if.master     bus
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int AW = $clog2(DEPTH);
   localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_START     = 3'd1;
   localparam logic [2:0] S_DATA      = 3'd2;
   localparam logic [2:0] S_STOP      = 3'd3;
   localparam logic [2:0] S_WAIT_HIGH = 3'd4;

   logic          sync1_q, sync1_d, sync2_q, sync2_d;
   logic [2:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    sh_q, sh_d;
   logic          push_q, push_d;
   logic          frame_err_q, frame_err_d;
   logic          overrun_q, overrun_d;
   logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [7:0]    mem_q [DEPTH];
   logic [7:0]    mem_d [DEPTH];

   logic s, empty, full, pop, wr_en, ovf;

   assign s = sync2_q;

   always_comb begin
      sync1_d     = uart_line_in;
      sync2_d     = sync1_q;
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      sh_d        = sh_q;
      push_d      = 1'b0;
      frame_err_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (!s) state_d = S_START;
         end
         S_START: begin
            if (cnt_q == HALF_M1) begin
               cnt_d   = '0;
               idx_d   = 3'd0;
               state_d = s ? S_IDLE : S_DATA;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DATA: begin
            if (cnt_q == FULL_M1) begin
               cnt_d = '0;
               sh_d  = {s, sh_q[7:1]};
               idx_d = idx_q + 3'd1;
               if (idx_q == 3'd7) state_d = S_STOP;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_STOP: begin
            if (cnt_q == FULL_M1) begin
               cnt_d = '0;
               // Leaving at mid-stop-bit lets an immediately following start edge be seen.
               if (s) begin
                  push_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = S_WAIT_HIGH;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_WAIT_HIGH: begin
            if (s) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // The assembled byte stays in sh_q until the next frame's data bits, so the
   // registered push can still write it one cycle after the stop sample.
   always_comb begin
      empty    = (wr_ptr_q == rd_ptr_q);
      full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      pop      = !empty && bus.rx_ready;
      wr_en    = push_q && (!full || pop);
      ovf      = push_q && full && !pop;
      mem_d    = mem_q;
      if (wr_en) mem_d[wr_ptr_q[AW-1:0]] = sh_q;
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, wr_en};
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
      overrun_d = ovf | (overrun_q & ~bus.err_clear);
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sync1_q     <= 1'b1;
         sync2_q     <= 1'b1;
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         idx_q       <= '0;
         sh_q        <= '0;
         push_q      <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         sh_q        <= sh_d;
         push_q      <= push_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         mem_q       <= mem_d;
      end
   end

   assign bus.rx_valid  = !empty;
   assign bus.rx_data   = mem_q[rd_ptr_q[AW-1:0]];
   assign bus.frame_err = frame_err_q;
   assign bus.overrun   = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// tb_uart_rx: random and directed frames checked against a byte-queue model of the receiver.
`default_nettype none

module tb_uart_rx;
   localparam int CPB   = 8;
   localparam int DEPTH = 4;

   logic CLK   = 1'b0;
   logic RST_N = 1'b0;
   logic line  = 1'b1;

   uart_rx_if bus ();

   uart_rx #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
      .CLK          (CLK),
      .RST_N        (RST_N),
      .uart_line_in (line),
      .bus          (bus)
   );

   always #5 CLK = ~CLK;

   int          total = 0;
   int          bad   = 0;
   logic [7:0]  model_q [$];
   bit          exp_ovr;
   int          exp_fe;
   int          fe_cnt = 0;
   time         rise_t = 0;
   logic        v_prev = 1'b0;
   int          push_lat = 80;

   always @(negedge CLK) begin
      if (bus.frame_err === 1'b1) fe_cnt = fe_cnt + 1;
      if (bus.rx_valid === 1'b1 && v_prev !== 1'b1) rise_t = $time;
      v_prev = bus.rx_valid;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic bit_time(input logic v);
      line = v;
      repeat (CPB) @(negedge CLK);
   endtask

   task automatic send(input logic [7:0] b, input bit stop_ok);
      bit_time(1'b0);
      for (int i = 0; i < 8; i++) bit_time(b[i]);
      bit_time(stop_ok);
      line = 1'b1;
   endtask

   task automatic idle(input int n);
      line = 1'b1;
      repeat (n) @(negedge CLK);
   endtask

   // What the receiver should do with a frame while nobody is popping.
   task automatic model_rx(input logic [7:0] b, input bit stop_ok);
      if (!stop_ok) exp_fe++;
      else if (model_q.size() < DEPTH) model_q.push_back(b);
      else exp_ovr = 1'b1;
   endtask

   task automatic pop_expect(input string tag);
      logic [7:0] e;
      int w;
      e = model_q.pop_front();
      w = 0;
      while (bus.rx_valid !== 1'b1 && w < 300) begin
         @(negedge CLK);
         w++;
      end
      chk({tag, "_valid"}, {31'd0, bus.rx_valid}, 32'd1);
      chk(tag, {24'd0, bus.rx_data}, {24'd0, e});
      bus.rx_ready = 1'b1;
      @(negedge CLK);
      bus.rx_ready = 1'b0;
   endtask

   task automatic drain(input string tag);
      while (model_q.size() > 0) pop_expect(tag);
      chk({tag, "_empty"}, {31'd0, bus.rx_valid}, 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      time t0;
      int  lat;
      int  n;
      logic [7:0] b;
      bit  ok;

      bus.rx_ready  = 1'b0;
      bus.err_clear = 1'b0;
      exp_ovr = 1'b0;
      exp_fe  = 0;
      repeat (3) @(negedge CLK);
      chk("rst_valid", {31'd0, bus.rx_valid}, 32'd0);
      chk("rst_data", {24'd0, bus.rx_data}, 32'd0);
      chk("rst_fe", {31'd0, bus.frame_err}, 32'd0);
      chk("rst_ovr", {31'd0, bus.overrun}, 32'd0);
      RST_N = 1'b1;
      idle(5);

      // Single byte and latency
      rise_t = 0;
      t0 = $time;
      send(8'hA5, 1'b1);
      model_rx(8'hA5, 1'b1);
      idle(4);
      lat = int'((rise_t - t0) / 10);
      chk("latency", (lat >= 79 && lat <= 81) ? 32'd80 : lat, 32'd80);
      if (lat >= 79 && lat <= 81) push_lat = lat;
      chk("single_fe", fe_cnt, 0);
      pop_expect("single");
      chk("single_valid_low", {31'd0, bus.rx_valid}, 32'd0);

      // Back-to-back bytes
      send(8'h00, 1'b1); model_rx(8'h00, 1'b1);
      send(8'hFF, 1'b1); model_rx(8'hFF, 1'b1);
      send(8'h3C, 1'b1); model_rx(8'h3C, 1'b1);
      idle(4);
      drain("b2b");
      chk("b2b_ovr", {31'd0, bus.overrun}, 32'd0);

      // Glitch on idle line
      fe_cnt = 0;
      line = 1'b0;
      repeat (3) @(negedge CLK);
      idle(100);
      chk("glitch_valid", {31'd0, bus.rx_valid}, 32'd0);
      chk("glitch_fe", fe_cnt, 0);

      // Bad stop bit
      send(8'h55, 1'b0);
      idle(10);
      chk("badstop_fe", fe_cnt, 1);
      chk("badstop_valid", {31'd0, bus.rx_valid}, 32'd0);

      // Break
      fe_cnt = 0;
      line = 1'b0;
      repeat (30 * CPB) @(negedge CLK);
      idle(20);
      chk("break_fe", fe_cnt, 1);
      send(8'h81, 1'b1); model_rx(8'h81, 1'b1);
      idle(4);
      drain("after_break");

      // Random bursts that never exceed the FIFO
      for (int r = 0; r < 6; r++) begin
         fe_cnt = 0;
         exp_fe = 0;
         n = $urandom_range(1, DEPTH);
         for (int k = 0; k < n; k++) begin
            b  = 8'($urandom);
            ok = ($urandom_range(0, 4) != 0);
            send(b, ok);
            model_rx(b, ok);
            if (!ok) idle(4);
            else idle($urandom_range(0, 12));
         end
         idle(4);
         chk("rnd_fe", fe_cnt, exp_fe);
         drain("rnd");
         chk("rnd_ovr", {31'd0, bus.overrun}, 32'd0);
      end

      // Overrun
      exp_ovr = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         send(8'(i), 1'b1);
         model_rx(8'(i), 1'b1);
      end
      idle(4);
      chk("ovr_set", {31'd0, bus.overrun}, {31'd0, exp_ovr});
      drain("ovr");
      chk("ovr_sticky", {31'd0, bus.overrun}, 32'd1);
      bus.err_clear = 1'b1;
      @(negedge CLK);
      bus.err_clear = 1'b0;
      chk("ovr_clear", {31'd0, bus.overrun}, 32'd0);

      // Full FIFO with a pop coinciding with the push
      exp_ovr = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         send(8'h10 + 8'(i), 1'b1);
         model_rx(8'h10 + 8'(i), 1'b1);
      end
      idle(4);
      fork
         send(8'h16, 1'b1);
         begin
            repeat (push_lat - 1) @(negedge CLK);
            bus.rx_ready = 1'b1;
            @(negedge CLK);
            bus.rx_ready = 1'b0;
         end
      join
      void'(model_q.pop_front());
      model_rx(8'h16, 1'b1);
      idle(4);
      chk("simul_ovr", {31'd0, bus.overrun}, {31'd0, exp_ovr});
      drain("simul");

      // Reset during data bit 4 with two bytes queued
      send(8'h21, 1'b1); model_rx(8'h21, 1'b1);
      send(8'h22, 1'b1); model_rx(8'h22, 1'b1);
      idle(4);
      chk("pre_rst_valid", {31'd0, bus.rx_valid}, 32'd1);
      b = 8'h33;
      bit_time(1'b0);
      for (int i = 0; i < 4; i++) bit_time(b[i]);
      line = b[4];
      repeat (3) @(negedge CLK);
      #2 RST_N = 1'b0;
      #1;
      chk("midrst_valid", {31'd0, bus.rx_valid}, 32'd0);
      chk("midrst_ovr", {31'd0, bus.overrun}, 32'd0);
      line = 1'b1;
      model_q.delete();
      repeat (3) @(negedge CLK);
      RST_N = 1'b1;
      idle(10);
      fe_cnt = 0;
      send(8'h7E, 1'b1); model_rx(8'h7E, 1'b1);
      idle(4);
      chk("post_rst_fe", fe_cnt, 0);
      drain("post_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/uart_rx.md
# uart_rx

Receive half of the board UART: oversamples the asynchronous `uart_line_in` serial line (8N1, LSB first), reassembles bytes, and presents them to the core through a small show-ahead FIFO with a valid/ready handshake. It fills the core's `uart_line_in` input, which is currently tied low, and is instantiated next to `top_uart` in the FPGA top-level, fed from the FTDI TX pin. It reports framing errors and overruns.

## Interface

- `CLKS_PER_BIT`, default 217 (25 MHz / 115200): clock cycles per bit; must be ≥ 4.
- `DEPTH`, default 4: FIFO entries; power of two, ≥ 2.
- `CLK`  in  1  single clock, rising edge.
- `RST_N`  in  1  reset; asynchronous, active-low.
- `uart_line_in`  in  1  asynchronous serial line; idles high.
- `rx_data`  out  8  FIFO head byte; valid only when `rx_valid`=1.
- `rx_valid`  out  1  FIFO non-empty.
- `rx_ready`  in  1  consumer accepts the head byte this cycle.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun`  out  1  sticky: a byte was dropped because the FIFO was full.
- `err_clear`  in  1  clears `overrun`.

## Operation

- Synchronizer: two flops on `uart_line_in`, both reset to 1. All logic uses the synced value `s`.
- Bit counter: width `$clog2(CLKS_PER_BIT)`. Bit index: 3 bits. Shift register: 8 bits, shifted right with the sampled bit entering at bit 7.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH. Reset state is IDLE.
- IDLE: when `s`=0, go to START and clear the counter.
- START: count to `CLKS_PER_BIT/2 - 1` (integer divide), then sample `s`.
  - `s`=1: glitch, return to IDLE. No error is raised.
  - `s`=0: go to DATA with bit index 0.
- DATA: count `CLKS_PER_BIT - 1`, then sample `s` into the shift register.
  - After bit index 7 is sampled, go to STOP.
- STOP: count `CLKS_PER_BIT - 1`, then sample `s`.
  - `s`=1: push the byte to the FIFO and go to IDLE.
  - `s`=0: pulse `frame_err`, drop the byte, go to WAIT_HIGH.
- WAIT_HIGH: stay until `s`=1, then go to IDLE. A break condition produces exactly one `frame_err`.
- FIFO: `DEPTH` entries, with read and write pointers one bit wider than the address.
  - Empty: pointers equal. Full: MSBs differ and the rest are equal.
  - Pop on `rx_valid && rx_ready`.
- Push while full and no pop in the same cycle: drop the byte and set `overrun`.
- Push while full with a pop in the same cycle: both happen and `overrun` is not set.
- Push while empty: `rx_valid` rises the next cycle. There is no bypass path.
- `err_clear` and an overrun event in the same cycle: `overrun` stays 1 (set wins).
- `rx_ready` while `rx_valid`=0: ignored.

## Timing

- Reset values: `rx_valid`=0, `rx_data`=0, `frame_err`=0, `overrun`=0. Pointers, counter, bit index and shift register are all 0; FSM is IDLE.
- Reset asserted mid-frame aborts the frame and empties the FIFO immediately (asynchronous).
  - After release the FSM is IDLE. If the line is low, this is treated as a start edge.
- Latency, measured from the first `CLK` edge that sees the pin low:
  - +2 cycles to reach `s`.
  - START sample occurs `CLKS_PER_BIT/2` cycles after entering START.
  - Each data sample and the stop sample follows the previous sample by `CLKS_PER_BIT` cycles.
  - `rx_valid` rises 1 cycle after the stop sample.
  - Total: 2 + 1 + `CLKS_PER_BIT/2` + 9·`CLKS_PER_BIT` + 1 cycles, ±1 cycle of pin phase.
- `frame_err` is high in the cycle after the stop sample. It is never high for two consecutive cycles.
- Back-to-back frames: the STOP→IDLE transition takes effect at the stop sample (mid-stop-bit). A start bit immediately following is detected.
- Throughput: one byte per 10·`CLKS_PER_BIT` cycles. The consumer may pop one byte per cycle.

## Test plan

Benches run with `CLKS_PER_BIT`=8 and `DEPTH`=4, driving 80-cycle frames.

- Single byte: drive 0xA5 with `rx_ready`=0. Required: `rx_valid`=1 and `rx_data`=0xA5 within the latency bound ±1; no `frame_err`. Then pulse `rx_ready` for one cycle → `rx_valid`=0 the next cycle.
- Back-to-back bytes: send 0x00, 0xFF, 0x3C with no idle gap. Required: three pops return 0x00, 0xFF, 0x3C in order; `overrun`=0.
- Glitch and framing:
  - A 3-cycle low pulse on idle gives no `rx_valid` and no `frame_err`.
  - Byte 0x55 with the stop bit low gives exactly one `frame_err` pulse and no push.
  - Holding the line low for 30 bit times (break) still gives one `frame_err`; reception of 0x81 afterwards works.
- Overrun:
  - Send 5 bytes 0x01–0x05 with `rx_ready`=0. Required: `overrun`=1 after byte 5; pops return 0x01–0x04.
  - Pulse `err_clear` → `overrun`=0.
  - With the FIFO full and `rx_ready`=1 held during byte 6's stop sample: no overrun, and byte 6 is retained.
- Reset mid-operation: assert `RST_N`=0 during data bit 4, with 2 bytes queued. Required: `rx_valid`=0 immediately and `overrun`=0. After release, 0x7E is received correctly.
